figo_seq_detector: RTL and testbench

- Parametrised successor of the FIGO serial sequence-detector FSM.
- Watches one serial bit stream against NUM_PAT independently programmable patterns of PAT_W bits each.
- Raises a one-cycle detect pulse per channel and keeps a saturating match count per channel.
- Supports run-time overlap/non-overlap mode, a qualifying valid strobe, pattern reload and synchronous clear; sits between the serial input front-end and the control/status logic.

---
 rtl/figo_seq_detector.sv | 110 +++++++++++
 tb/tb_figo_seq_detector.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/figo_seq_detector.sv
// rtl/figo_seq_detector.sv - multi-channel serial sequence detector with saturating match counters
//
// Purpose: shifts a qualified serial bit stream into a PAT_W-bit history and
// compares it against NUM_PAT run-time programmable patterns. Each channel
// has its own fill counter, so overlapping and non-overlapping matching can
// be selected per edge. Each channel also has a one-cycle detect pulse and a
// saturating match counter.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   inbit      serial data bit, sampled only when in_valid=1
//   in_valid   qualifies inbit
//   overlap_en 1 = overlapping matches, 0 = a match restarts that channel's fill
//   clear      synchronous clear of history, fill counters, counts and detect
//   pat_load   write pat_data into channel pat_sel (out-of-range index ignored)
//   pat_sel    channel index for pat_load
//   pat_data   new pattern, MSB = oldest bit
//   detect     registered one-cycle match pulse per channel
//   det_count  saturating match count, channel i at [i*CNT_W +: CNT_W]
module figo_seq_detector #(
  parameter int PAT_W = 3,
  parameter int NUM_PAT = 3,
  parameter int CNT_W = 8,
  parameter logic [NUM_PAT*PAT_W-1:0] PAT_INIT = {3'b010, 3'b101, 3'b110},
  localparam int SEL_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     inbit,
  input  logic                     in_valid,
  input  logic                     overlap_en,
  input  logic                     clear,
  input  logic                     pat_load,
  input  logic [SEL_W-1:0]         pat_sel,
  input  logic [PAT_W-1:0]         pat_data,
  output logic [NUM_PAT-1:0]       detect,
  output logic [NUM_PAT*CNT_W-1:0] det_count
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  // A channel can match once it holds PAT_W-1 bits, since the incoming bit completes the window.
  localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [PAT_W-1:0]                  hist_q, hist_d, next_hist;
  logic [NUM_PAT-1:0][FILL_W-1:0]    fill_q, fill_d;
  logic [NUM_PAT-1:0][PAT_W-1:0]     pat_q, pat_d;
  logic [NUM_PAT-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_PAT-1:0]                det_q, det_d, match;

  always_comb begin
    next_hist = {hist_q[PAT_W-2:0], inbit};
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    det_d     = '0;
    match     = '0;

    // The compare uses pat_q, so a load on the same edge only affects later bits.
    for (int i = 0; i < NUM_PAT; i++) begin
      match[i] = in_valid && (next_hist == pat_q[i]) && (fill_q[i] >= FILL_THR);
    end

    if (clear) begin
      // Clear wins over in_valid; the bit presented on this edge is dropped.
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (in_valid) begin
      hist_d = next_hist;
      for (int i = 0; i < NUM_PAT; i++) begin
        if (match[i]) begin
          det_d[i] = 1'b1;
          if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
          fill_d[i] = overlap_en ? FILL_MAX : '0;
        end else if (fill_q[i] != FILL_MAX) begin
          fill_d[i] = fill_q[i] + 1'b1;
        end
      end
    end

    // Out-of-range pat_sel matches no channel and so is ignored.
    for (int i = 0; i < NUM_PAT; i++) begin
      if (pat_load && (pat_sel == SEL_W'(i))) pat_d[i] = pat_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      det_q  <= '0;
      pat_q  <= PAT_INIT;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      det_q  <= det_d;
      pat_q  <= pat_d;
    end
  end

  assign detect    = det_q;
  assign det_count = cnt_q;

endmodule

// File: tb/tb_figo_seq_detector.sv
// tb/tb_figo_seq_detector.sv - directed self-checking bench for figo_seq_detector
module tb_figo_seq_detector;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        inbit = 1'b0;
  logic        in_valid = 1'b0;
  logic        overlap_en = 1'b1;
  logic        clear = 1'b0;
  logic        pat_load = 1'b0;
  logic [1:0]  pat_sel = 2'd0;
  logic [2:0]  pat_data = 3'b000;
  logic [2:0]  detect, detect2;
  logic [23:0] det_count;
  logic [5:0]  det_count2;

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  figo_seq_detector dut (
    .clk(clk), .reset_n(reset_n), .inbit(inbit), .in_valid(in_valid),
    .overlap_en(overlap_en), .clear(clear), .pat_load(pat_load),
    .pat_sel(pat_sel), .pat_data(pat_data), .detect(detect), .det_count(det_count)
  );

  figo_seq_detector #(.CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .inbit(inbit), .in_valid(in_valid),
    .overlap_en(overlap_en), .clear(clear), .pat_load(pat_load),
    .pat_sel(pat_sel), .pat_data(pat_data), .detect(detect2), .det_count(det_count2)
  );

  task automatic drive_bit(input logic b);
    inbit = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (detect !== 3'b000) begin
      errors++; $display("FAIL reset_detect: got %b expected 000", detect);
    end
    tests++;
    if (det_count !== 24'd0) begin
      errors++; $display("FAIL reset_count: got %h expected 000000", det_count);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_defaults();
    logic [4:0] s;
    logic [2:0] e [5];
    s = 5'b11010;
    e = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b100};
    overlap_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_bit(s[4-k]);
      tests++;
      if (detect !== e[k]) begin
        errors++; $display("FAIL defaults_bit%0d: detect=%b expected %b", k + 1, detect, e[k]);
      end
    end
    idle_cycle();
    tests++;
    if (detect !== 3'b000) begin
      errors++; $display("FAIL defaults_idle: detect=%b expected 000", detect);
    end
    tests++;
    if (det_count !== {8'd1, 8'd1, 8'd1}) begin
      errors++; $display("FAIL defaults_count: got %h expected 010101", det_count);
    end
  endtask

  task automatic test_overlap(input logic ov);
    logic [4:0] s;
    logic [2:0] e [5];
    logic [23:0] ec;
    s = 5'b10101;
    if (ov) begin
      e  = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b010};
      ec = {8'd1, 8'd2, 8'd0};
    end else begin
      e  = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b000};
      ec = {8'd1, 8'd1, 8'd0};
    end
    do_clear();
    overlap_en = ov;
    for (int k = 0; k < 5; k++) begin
      drive_bit(s[4-k]);
      tests++;
      if (detect !== e[k]) begin
        errors++; $display("FAIL overlap%0b_bit%0d: detect=%b expected %b", ov, k + 1, detect, e[k]);
      end
    end
    tests++;
    if (det_count !== ec) begin
      errors++; $display("FAIL overlap%0b_count: got %h expected %h", ov, det_count, ec);
    end
    overlap_en = 1'b1;
  endtask

  task automatic test_gap();
    do_clear();
    drive_bit(1'b1);
    drive_bit(1'b1);
    for (int k = 0; k < 4; k++) begin
      idle_cycle();
      tests++;
      if (detect !== 3'b000) begin
        errors++; $display("FAIL gap_idle%0d: detect=%b expected 000", k, detect);
      end
    end
    drive_bit(1'b0);
    tests++;
    if (detect !== 3'b001) begin
      errors++; $display("FAIL gap_final: detect=%b expected 001", detect);
    end
  endtask

  task automatic test_pat_load();
    logic [5:0] s;
    logic [2:0] e [6];
    s = 6'b010111;
    e = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b000, 3'b100};
    do_clear();
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin
        pat_load = 1'b1; pat_sel = 2'd2; pat_data = 3'b111;
      end
      drive_bit(s[5-k]);
      pat_load = 1'b0;
      tests++;
      if (detect !== e[k]) begin
        errors++; $display("FAIL patload_bit%0d: detect=%b expected %b", k + 1, detect, e[k]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [3:0] s;
    logic [2:0] e [4];
    s = 4'b0110;
    e = '{3'b000, 3'b000, 3'b000, 3'b001};
    do_clear();
    for (int k = 0; k < 6; k++) begin
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b0);
    end
    tests++;
    if (det_count[7:0] !== 8'd6) begin
      errors++; $display("FAIL sat_count8: got %0d expected 6", det_count[7:0]);
    end
    tests++;
    if (det_count2[1:0] !== 2'd3) begin
      errors++; $display("FAIL sat_count2: got %0d expected 3", det_count2[1:0]);
    end
    drive_bit(1'b1);
    drive_bit(1'b1);
    do_clear();
    tests++;
    if (det_count !== 24'd0 || det_count2 !== 6'd0) begin
      errors++; $display("FAIL sat_clear: got %h/%h expected 0/0", det_count, det_count2);
    end
    for (int k = 0; k < 4; k++) begin
      drive_bit(s[3-k]);
      tests++;
      if (detect !== e[k]) begin
        errors++; $display("FAIL sat_fresh_bit%0d: detect=%b expected %b", k + 1, detect, e[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] s;
    logic [2:0] e [3];
    s = 3'b010;
    e = '{3'b000, 3'b000, 3'b100};
    drive_bit(1'b1);
    drive_bit(1'b1);
    reset_n = 1'b0;
    #2;
    tests++;
    if (detect !== 3'b000 || det_count !== 24'd0) begin
      errors++; $display("FAIL resetmid_hold: detect=%b count=%h expected 000/000000", detect, det_count);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_bit(s[2-k]);
      tests++;
      if (detect !== e[k]) begin
        errors++; $display("FAIL resetmid_bit%0d: detect=%b expected %b", k + 1, detect, e[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_overlap(1'b1);
    test_overlap(1'b0);
    test_gap();
    test_pat_load();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
